// File: rtl/instr_loader_pkg.sv
// Shared opcode/funct encodings and the request-to-instruction-word encoder
// for the instruction loader front end.
`timescale 1ns/1ps
package instr_loader_pkg;

  localparam logic [3:0] OP_LOAD    = 4'b0000;
  localparam logic [3:0] OP_STORE   = 4'b0001;
  localparam logic [3:0] OP_JUMP    = 4'b0010;
  localparam logic [3:0] OP_BRANCHZ = 4'b0100;
  localparam logic [3:0] OP_TYPEC   = 4'b1000;
  localparam logic [3:0] OP_ADDI    = 4'b1100;
  localparam logic [3:0] OP_SUBI    = 4'b1101;
  localparam logic [3:0] OP_ANDI    = 4'b1110;
  localparam logic [3:0] OP_ORI     = 4'b1111;

  localparam logic [7:0] FN_ADD = 8'b0000_0010;
  localparam logic [7:0] FN_SUB = 8'b0000_0100;
  localparam logic [7:0] FN_AND = 8'b0000_1000;
  localparam logic [7:0] FN_OR  = 8'b0001_0000;
  localparam logic [7:0] FN_NOP = 8'b0100_0000;

  typedef enum logic [3:0] {
    K_LOAD    = 4'd0,
    K_STORE   = 4'd1,
    K_JUMP    = 4'd2,
    K_BRANCHZ = 4'd3,
    K_ADD     = 4'd4,
    K_SUB     = 4'd5,
    K_AND     = 4'd6,
    K_OR      = 4'd7,
    K_ADDI    = 4'd8,
    K_SUBI    = 4'd9,
    K_ANDI    = 4'd10,
    K_ORI     = 4'd11
  } req_kind_e;

  function automatic logic kind_legal(input logic [3:0] kind);
    return kind <= 4'd11;
  endfunction

  function automatic logic [15:0] encode(input logic [3:0]  kind,
                                         input logic [1:0]  ri,
                                         input logic [1:0]  rj,
                                         input logic [11:0] val);
    logic [15:0] w;
    w = {4'b0000, ri, 2'b00, val[7:0]};
    case (kind)
      K_LOAD:    w[15:12] = OP_LOAD;
      K_STORE:   w[15:12] = OP_STORE;
      K_JUMP:    w = {OP_JUMP, val};
      K_BRANCHZ: w[15:12] = OP_BRANCHZ;
      K_ADD:     w = {OP_TYPEC, ri, rj, FN_ADD};
      K_SUB:     w = {OP_TYPEC, ri, rj, FN_SUB};
      K_AND:     w = {OP_TYPEC, ri, rj, FN_AND};
      K_OR:      w = {OP_TYPEC, ri, rj, FN_OR};
      K_ADDI:    w[15:12] = OP_ADDI;
      K_SUBI:    w[15:12] = OP_SUBI;
      K_ANDI:    w[15:12] = OP_ANDI;
      K_ORI:     w[15:12] = OP_ORI;
      default:   w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Request handshake and instruction-memory write bus of the loader.
`timescale 1ns/1ps
interface instr_loader_if #(parameter int unsigned AW = 8);

  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_kind;
  logic [1:0]    req_ri;
  logic [1:0]    req_rj;
  logic [11:0]   req_val;
  logic          req_last;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [15:0]   im_wdata;
  logic          im_ready;

  // Environment side: issues requests and plays the instruction memory.
  modport master (
    output req_valid, req_kind, req_ri, req_rj, req_val, req_last, im_ready,
    input  req_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    input  req_valid, req_kind, req_ri, req_rj, req_val, req_last, im_ready,
    output req_ready, im_we, im_addr, im_wdata
  );

endinterface

// File: rtl/instr_loader_sync_fifo.sv
// Small synchronous FIFO with flush; full/empty depend only on registered pointers.
`timescale 1ns/1ps
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign rdata   = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[PW-1:0]] <= wdata;
  end

endmodule

// File: rtl/instr_loader.sv
// Encodes symbolic requests, buffers them, and writes the program into
// instruction memory while holding the core in reset.
`timescale 1ns/1ps
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned AW          = 8,
  parameter bit          APPEND_HALT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  instr_loader_if.slave     bus,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_HALT  = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd4;

  logic [2:0]  state;
  logic [2:0]  state_nx;
  // Top bit is the wrap flag; once set no write fires, so the count saturates.
  logic [AW:0] cnt;
  logic        ovf;
  logic [15:0] enc_word;
  logic [15:0] fifo_head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_push;
  logic        fifo_pop;
  logic        accept;
  logic        legal;
  logic        wr_attempt;
  logic        wr_fire;

  assign ovf        = cnt[AW];
  assign enc_word   = encode(bus.req_kind, bus.req_ri, bus.req_rj, bus.req_val);
  assign legal      = kind_legal(bus.req_kind);

  assign bus.req_ready = (state == S_FILL) && !fifo_full;
  assign accept        = bus.req_valid && bus.req_ready;
  assign fifo_push     = accept && legal;

  // Overflowed words are discarded without waiting for the memory.
  assign wr_attempt = (state == S_HALT) || !fifo_empty;
  assign bus.im_we  = wr_attempt && !ovf;
  assign wr_fire    = bus.im_we && bus.im_ready;
  assign fifo_pop   = !fifo_empty && (ovf || bus.im_ready);

  assign bus.im_addr  = cnt[AW-1:0];
  assign bus.im_wdata = (state == S_HALT) ? {OP_JUMP, 12'(cnt[AW-1:0])}
                      : (fifo_empty ? '0 : fifo_head);

  assign cpu_rst = (state != S_RUN);
  assign done    = (state == S_RUN);

  sync_fifo #(
    .WIDTH (16),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (start),
    .push  (fifo_push),
    .wdata (enc_word),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_nx = state;
    if (start) begin
      state_nx = S_FILL;
    end else begin
      case (state)
        S_IDLE:  state_nx = S_IDLE;
        S_FILL:  if (accept && bus.req_last) state_nx = S_DRAIN;
        S_DRAIN: if (fifo_empty) state_nx = APPEND_HALT ? S_HALT : S_RUN;
        S_HALT:  if (ovf || bus.im_ready) state_nx = S_RUN;
        S_RUN:   state_nx = S_RUN;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (start) begin
        cnt <= '0;
        err <= 1'b0;
      end else begin
        if (wr_fire) cnt <= cnt + (AW+1)'(1);
        if ((accept && !legal) || (wr_attempt && ovf)) err <= 1'b1;
      end
    end
  end

endmodule
